// File: rtl/wb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : wb_set_assoc_cache
// Description : Write-back, write-allocate N-way set-associative data cache,
//               one 32-bit word per line, with dirty tracking, victim
//               write-back, explicit flush, hit/miss counters and memory
//               error propagation.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_set_assoc_cache #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic                  core_we_i,
    input  logic [3:0]            core_be_i,
    input  logic [31:0]           core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    output logic                  core_error_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic                  mem_error_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int C_IDX_W = $clog2(SETS);
    localparam int C_TAG_W = ADDR_WIDTH - 2 - C_IDX_W;
    localparam int C_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT,
        S_RESP, S_FLUSH_SCAN, S_FLUSH_WB_REQ, S_FLUSH_WB_WAIT
    } state_t;

    // Line storage: valid/dirty per way, tag and data per way, round-robin pointer per set
    logic [WAYS-1:0]    r_valid [SETS];
    logic [WAYS-1:0]    r_dirty [SETS];
    logic [C_TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [31:0]        r_data  [SETS][WAYS];
    logic [C_WAY_W-1:0] r_rr    [SETS];

    state_t                r_state;
    logic                  r_flush_pend;
    logic [ADDR_WIDTH-3:0] r_word;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic                  r_hit;
    logic [C_WAY_W-1:0]    r_way;
    logic [C_IDX_W-1:0]    r_fset;
    logic [C_WAY_W-1:0]    r_fway;

    logic [C_IDX_W-1:0] w_idx;
    logic [C_TAG_W-1:0] w_tag;
    logic [C_IDX_W-1:0] w_ridx;
    logic               w_hit;
    logic [C_WAY_W-1:0] w_hit_way;
    logic               w_inv_found;
    logic [C_WAY_W-1:0] w_inv_way;
    logic [C_WAY_W-1:0] w_vic_way;
    logic               w_flush_last;
    logic               w_unused_addr_bits;

    assign w_idx              = core_addr_i[2 +: C_IDX_W];
    assign w_tag              = core_addr_i[ADDR_WIDTH-1 -: C_TAG_W];
    assign w_ridx             = r_word[0 +: C_IDX_W];
    assign w_unused_addr_bits = ^core_addr_i[1:0];
    assign w_vic_way          = w_inv_found ? w_inv_way : r_rr[w_idx];
    assign w_flush_last       = (r_fset == C_IDX_W'(SETS - 1)) && (r_fway == C_WAY_W'(WAYS - 1));

    assign core_gnt_o = core_req_i && (r_state == S_IDLE) && !r_flush_pend;
    assign mem_be_o   = mem_req_o ? 4'hF : 4'h0;

    function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        f_merge = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) f_merge[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    // Tag compare of the incoming address; also picks the lowest invalid way for a miss
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = C_WAY_W'(w);
            end
            if (!w_inv_found && !r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = C_WAY_W'(w);
            end
        end
    end

    // Controller: lookup, victim write-back, fill, flush walk and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_flush_pend  <= 1'b0;
            r_word        <= '0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_hit         <= 1'b0;
            r_way         <= '0;
            r_fset        <= '0;
            r_fway        <= '0;
            core_rvalid_o <= 1'b0;
            core_rdata_o  <= '0;
            core_error_o  <= 1'b0;
            flush_done_o  <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_we_o      <= 1'b0;
            mem_wdata_o   <= '0;
            hit_count_o   <= '0;
            miss_count_o  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            core_rvalid_o <= 1'b0;
            core_error_o  <= 1'b0;
            flush_done_o  <= 1'b0;
            // A flush arriving while a core request is in progress waits its turn
            if (flush_i && (r_state inside {S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ,
                                            S_FILL_WAIT, S_RESP})) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (core_gnt_o) begin
                        r_word  <= core_addr_i[ADDR_WIDTH-1:2];
                        r_we    <= core_we_i;
                        r_be    <= core_be_i;
                        r_wdata <= core_wdata_i;
                        r_hit   <= w_hit;
                        r_way   <= w_hit ? w_hit_way : w_vic_way;
                        if (flush_i) r_flush_pend <= 1'b1;
                        // Hits are serviced at the grant edge so the response lands in LOOKUP
                        if (w_hit) begin
                            core_rvalid_o <= 1'b1;
                            hit_count_o   <= hit_count_o + 32'd1;
                            if (core_we_i) begin
                                r_data[w_idx][w_hit_way]  <= f_merge(r_data[w_idx][w_hit_way],
                                                                     core_wdata_i, core_be_i);
                                r_dirty[w_idx][w_hit_way] <= 1'b1;
                            end else begin
                                core_rdata_o <= r_data[w_idx][w_hit_way];
                            end
                        end
                        r_state <= S_LOOKUP;
                    end else if (flush_i || r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        r_fset       <= '0;
                        r_fway       <= '0;
                        r_state      <= S_FLUSH_SCAN;
                    end
                end
                S_LOOKUP: begin
                    if (r_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        miss_count_o <= miss_count_o + 32'd1;
                        mem_req_o    <= 1'b1;
                        if (r_valid[w_ridx][r_way] && r_dirty[w_ridx][r_way]) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {r_tag[w_ridx][r_way], w_ridx, 2'b00};
                            mem_wdata_o <= r_data[w_ridx][r_way];
                            r_state     <= S_WB_REQ;
                        end else begin
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {r_word, 2'b00};
                            r_state    <= S_FILL_REQ;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= S_WB_WAIT;
                    end
                end
                S_WB_WAIT: begin
                    // Victim is dropped even if its write-back reported an error
                    if (mem_rvalid_i) begin
                        r_valid[w_ridx][r_way] <= 1'b0;
                        r_dirty[w_ridx][r_way] <= 1'b0;
                        mem_req_o              <= 1'b1;
                        mem_we_o               <= 1'b0;
                        mem_addr_o             <= {r_word, 2'b00};
                        r_state                <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_rvalid_i) begin
                        core_rvalid_o <= 1'b1;
                        core_error_o  <= mem_error_i;
                        if (mem_error_i) begin
                            r_valid[w_ridx][r_way] <= 1'b0;
                            r_dirty[w_ridx][r_way] <= 1'b0;
                        end else begin
                            r_valid[w_ridx][r_way] <= 1'b1;
                            r_dirty[w_ridx][r_way] <= r_we;
                            r_tag[w_ridx][r_way]   <= r_word[ADDR_WIDTH-3 -: C_TAG_W];
                            r_data[w_ridx][r_way]  <= r_we ? f_merge(mem_rdata_i, r_wdata, r_be)
                                                           : mem_rdata_i;
                            r_rr[w_ridx]           <= (r_rr[w_ridx] == C_WAY_W'(WAYS - 1)) ? '0
                                                      : r_rr[w_ridx] + C_WAY_W'(1);
                            if (!r_we) core_rdata_o <= mem_rdata_i;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                S_FLUSH_SCAN, S_FLUSH_WB_WAIT: begin
                    if ((r_state == S_FLUSH_SCAN) && r_dirty[r_fset][r_fway]) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {r_tag[r_fset][r_fway], r_fset, 2'b00};
                        mem_wdata_o <= r_data[r_fset][r_fway];
                        r_state     <= S_FLUSH_WB_REQ;
                    end else if ((r_state == S_FLUSH_SCAN) || mem_rvalid_i) begin
                        r_valid[r_fset][r_fway] <= 1'b0;
                        r_dirty[r_fset][r_fway] <= 1'b0;
                        if (w_flush_last) begin
                            flush_done_o <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            if (r_fway == C_WAY_W'(WAYS - 1)) begin
                                r_fway <= '0;
                                r_fset <= r_fset + C_IDX_W'(1);
                            end else begin
                                r_fway <= r_fway + C_WAY_W'(1);
                            end
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                S_FLUSH_WB_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= S_FLUSH_WB_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
